// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: self-synchronising XNOR LFSR word-stream checker with saturating error/word counters
module lfsr_stream_checker #(
  parameter int NUM_BITS   = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Data_DV,
  input  logic [NUM_BITS-1:0]  i_Data,
  input  logic                 i_Clear,
  output logic                 o_Locked,
  output logic                 o_Err_Pulse,
  output logic [CNT_WIDTH-1:0] o_Err_Count,
  output logic [CNT_WIDTH-1:0] o_Word_Count
);
  function automatic logic [31:0] tp(input int a, input int b, input int c, input int d);
    tp = '0;
    for (int i = 1; i <= 32; i++) if (i == a || i == b || i == c || i == d) tp[i-1] = 1'b1;
  endfunction
  function automatic logic [31:0] taps(input int n);
    case (n)
      3:       taps = tp(3, 2, 0, 0);
      4:       taps = tp(4, 3, 0, 0);
      5:       taps = tp(5, 3, 0, 0);
      6:       taps = tp(6, 5, 0, 0);
      7:       taps = tp(7, 6, 0, 0);
      8:       taps = tp(8, 6, 5, 4);
      9:       taps = tp(9, 5, 0, 0);
      10:      taps = tp(10, 7, 0, 0);
      11:      taps = tp(11, 9, 0, 0);
      12:      taps = tp(12, 6, 4, 1);
      13:      taps = tp(13, 4, 3, 1);
      14:      taps = tp(14, 5, 3, 1);
      15:      taps = tp(15, 14, 0, 0);
      16:      taps = tp(16, 15, 13, 4);
      17:      taps = tp(17, 14, 0, 0);
      18:      taps = tp(18, 11, 0, 0);
      19:      taps = tp(19, 6, 2, 1);
      20:      taps = tp(20, 17, 0, 0);
      21:      taps = tp(21, 19, 0, 0);
      22:      taps = tp(22, 21, 0, 0);
      23:      taps = tp(23, 18, 0, 0);
      24:      taps = tp(24, 23, 22, 17);
      25:      taps = tp(25, 22, 0, 0);
      26:      taps = tp(26, 6, 2, 1);
      27:      taps = tp(27, 5, 2, 1);
      28:      taps = tp(28, 25, 0, 0);
      29:      taps = tp(29, 27, 0, 0);
      30:      taps = tp(30, 6, 4, 1);
      31:      taps = tp(31, 28, 0, 0);
      default: taps = tp(32, 22, 2, 1);
    endcase
  endfunction
  localparam logic [31:0]         TAP_ALL = taps(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP     = TAP_ALL[NUM_BITS-1:0];
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  // every tap row has an even tap count, so the XNOR chain reduces to inverted parity
  function automatic logic [NUM_BITS-1:0] nxt(input logic [NUM_BITS-1:0] x);
    return {x[NUM_BITS-2:0], ~^(x & TAP)};
  endfunction
  typedef enum logic {ACQUIRE, LOCKED} state_t;
  state_t                state, state_n;
  logic                  seeded, seeded_n, pulse_n, hit;
  logic [NUM_BITS-1:0]   expected, exp_n;
  logic [MW-1:0]         match, match_n;
  logic [LW-1:0]         miss, miss_n;
  logic [CNT_WIDTH-1:0]  err_n, word_n;
  assign o_Locked = state == LOCKED;
  always_comb begin
    state_n  = state;
    seeded_n = seeded;
    exp_n    = expected;
    match_n  = match;
    miss_n   = miss;
    pulse_n  = 1'b0;
    err_n    = o_Err_Count;
    word_n   = o_Word_Count;
    hit      = i_Data == expected;
    if (i_Data_DV && state == ACQUIRE) begin
      if (&i_Data) begin
        seeded_n = 1'b0;
        match_n  = '0;
      end else begin
        seeded_n = 1'b1;
        exp_n    = nxt(i_Data);
        match_n  = seeded && hit ? match + 1'b1 : '0;
        if (match_n == MW'(LOCK_COUNT)) begin
          state_n = LOCKED;
          miss_n  = '0;
        end
      end
    end else if (i_Data_DV) begin
      exp_n   = nxt(expected);
      pulse_n = !hit;
      word_n  = &o_Word_Count ? o_Word_Count : o_Word_Count + 1'b1;
      err_n   = hit || &o_Err_Count ? o_Err_Count : o_Err_Count + 1'b1;
      miss_n  = hit ? '0 : miss + 1'b1;
      if (miss_n == LW'(LOSS_COUNT)) begin
        state_n  = ACQUIRE;
        seeded_n = 1'b0;
        match_n  = '0;
      end
    end
    if (i_Clear) begin
      err_n  = '0;
      word_n = '0;
    end
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= ACQUIRE;
      seeded       <= 1'b0;
      expected     <= '0;
      match        <= '0;
      miss         <= '0;
      o_Err_Pulse  <= 1'b0;
      o_Err_Count  <= '0;
      o_Word_Count <= '0;
    end else begin
      state        <= state_n;
      seeded       <= seeded_n;
      expected     <= exp_n;
      match        <= match_n;
      miss         <= miss_n;
      o_Err_Pulse  <= pulse_n;
      o_Err_Count  <= err_n;
      o_Word_Count <= word_n;
    end
  end
endmodule
